// File: rtl/multi_layer_ctl_pkg.sv
// Shared types and helpers for the multi-layer command/data decoder.
// Feature macro used by the top: MULTI_LAYER_CTL_AUTO_SYNC_EN.
package multi_layer_ctl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MASK  = 2'd1,
        WRITE = 2'd2
    } state_e;

    localparam logic [7:0] DEF_CMD_LAYER_SEL  = 8'hCC;
    localparam logic [7:0] DEF_CMD_WR_START   = 8'hDA;
    localparam logic [7:0] DEF_CMD_FRAME_SYNC = 8'h3C;

    function automatic int mask_bytes(input int layers);
        return (layers + 7) / 8;
    endfunction

    function automatic int addr_w(input int leds);
        return (leds > 1) ? $clog2(leds) : 1;
    endfunction

    // Counter width that stays legal when only one value is ever needed.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multi_layer_ctl_pixel_write_cnt.sv
// LED address / colour-byte index counter with a full flag that freezes
// the address after the last byte of the last LED.
module pixel_write_cnt
    import multi_layer_ctl_pkg::*;
#(
    parameter int LEDS          = 64,
    parameter int BYTES_PER_LED = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     adv,
    output logic [$clog2(LEDS)-1:0]  addr,
    output logic [BYTES_PER_LED-1:0] byte_en,
    output logic                     full
);

    localparam int ADDR_W = addr_w(LEDS);
    localparam int IDX_W  = idx_w(BYTES_PER_LED);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(BYTES_PER_LED - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(LEDS - 1);

    logic [IDX_W-1:0] idx;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            addr <= '0;
            idx  <= '0;
            full <= 1'b0;
        end else if (adv && !full) begin
            if (idx == IDX_LAST) begin
                idx <= '0;
                // The address never wraps: the last LED only raises full.
                if (addr == ADDR_LAST)
                    full <= 1'b1;
                else
                    addr <= addr + ADDR_W'(1);
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

    assign byte_en = BYTES_PER_LED'(1) << idx;

endmodule

// File: rtl/multi_layer_ctl.sv
// Decodes the DC-qualified SPI byte stream into a layer mask, pixel write
// strobes and a frame-ready pulse. Optional: MULTI_LAYER_CTL_AUTO_SYNC_EN.
module multi_layer_ctl
    import multi_layer_ctl_pkg::*;
#(
    parameter int         LAYERS         = 8,
    parameter int         LEDS           = 64,
    parameter int         BYTES_PER_LED  = 3,
    parameter logic [7:0] CMD_LAYER_SEL  = DEF_CMD_LAYER_SEL,
    parameter logic [7:0] CMD_WR_START   = DEF_CMD_WR_START,
    parameter logic [7:0] CMD_FRAME_SYNC = DEF_CMD_FRAME_SYNC
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     dc_in,
    input  logic                     byte_rdy_in,
    input  logic [7:0]               byte_data_in,
    output logic                     frame_rdy_out,
    output logic                     wr_en_out,
    output logic [$clog2(LEDS)-1:0]  wr_addr_out,
    output logic [BYTES_PER_LED-1:0] byte_en_out,
    output logic [7:0]               byte_data_out,
    output logic [LAYERS-1:0]        layer_en_out,
    output logic                     overflow_out
);

    localparam int ADDR_W     = addr_w(LEDS);
    localparam int MASK_BYTES = mask_bytes(LAYERS);
    localparam int MCNT_W     = idx_w(MASK_BYTES);
    localparam int SHADOW_W   = MASK_BYTES * 8;
    localparam logic [MCNT_W-1:0] MCNT_LAST = MCNT_W'(MASK_BYTES - 1);

    state_e                   state;
    logic [MCNT_W-1:0]        mcnt;
    logic [SHADOW_W-1:0]      shadow;
    logic [SHADOW_W-1:0]      shadow_nxt;
    logic [ADDR_W-1:0]        cnt_addr;
    logic [BYTES_PER_LED-1:0] cnt_be;
    logic                     cnt_full;
    logic                     is_cmd;
    logic                     is_data;
    logic                     cnt_clr;
    logic                     cnt_adv;
    logic                     auto_sync;

    assign is_cmd  = byte_rdy_in && !dc_in;
    assign is_data = byte_rdy_in && dc_in;
    assign cnt_clr = is_cmd && (byte_data_in == CMD_WR_START);
    assign cnt_adv = is_data && (state == WRITE) && !cnt_full;

    pixel_write_cnt #(
        .LEDS          (LEDS),
        .BYTES_PER_LED (BYTES_PER_LED)
    ) u_cnt (
        .clk     (clk_in),
        .rst     (rst_in),
        .clr     (cnt_clr),
        .adv     (cnt_adv),
        .addr    (cnt_addr),
        .byte_en (cnt_be),
        .full    (cnt_full)
    );

    // Mask bytes land LSB-byte first; the live mask only changes on the last one.
    always_comb begin
        shadow_nxt = shadow;
        for (int i = 0; i < MASK_BYTES; i++) begin
            if (mcnt == MCNT_W'(i))
                shadow_nxt[i*8 +: 8] = byte_data_in;
        end
    end

`ifdef MULTI_LAYER_CTL_AUTO_SYNC_EN
    // The rising edge of full coincides with the final write strobe, so
    // registering it puts the pulse one cycle after that strobe.
    logic full_d;

    always_ff @(posedge clk_in) begin
        if (rst_in)
            full_d <= 1'b0;
        else
            full_d <= cnt_full;
    end

    assign auto_sync = cnt_full && !full_d;
`else
    assign auto_sync = 1'b0;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state         <= IDLE;
            mcnt          <= '0;
            shadow        <= '0;
            frame_rdy_out <= 1'b0;
            wr_en_out     <= 1'b0;
            wr_addr_out   <= '0;
            byte_en_out   <= '0;
            byte_data_out <= '0;
            layer_en_out  <= '0;
            overflow_out  <= 1'b0;
        end else begin
            frame_rdy_out <= auto_sync;
            wr_en_out     <= 1'b0;
            if (is_cmd) begin
                if (byte_data_in == CMD_LAYER_SEL) begin
                    state  <= MASK;
                    mcnt   <= '0;
                    shadow <= '0;
                end else if (byte_data_in == CMD_WR_START) begin
                    state        <= WRITE;
                    overflow_out <= 1'b0;
                end else if (byte_data_in == CMD_FRAME_SYNC) begin
                    state         <= IDLE;
                    frame_rdy_out <= 1'b1;
                end else begin
                    state <= IDLE;
                end
            end else if (is_data) begin
                case (state)
                    MASK: begin
                        shadow <= shadow_nxt;
                        if (mcnt == MCNT_LAST) begin
                            layer_en_out <= shadow_nxt[LAYERS-1:0];
                            state        <= IDLE;
                        end else begin
                            mcnt <= mcnt + MCNT_W'(1);
                        end
                    end
                    WRITE: begin
                        if (cnt_full) begin
                            overflow_out <= 1'b1;
                        end else begin
                            wr_en_out     <= 1'b1;
                            wr_addr_out   <= cnt_addr;
                            byte_en_out   <= cnt_be;
                            byte_data_out <= byte_data_in;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multi_layer_ctl.sv
// Self-checking bench for multi_layer_ctl (LAYERS=12, LEDS=4, BYTES_PER_LED=3);
// expectations follow MULTI_LAYER_CTL_AUTO_SYNC_EN when it is defined.
module tb_multi_layer_ctl;

`ifdef MULTI_LAYER_CTL_AUTO_SYNC_EN
    localparam logic AUTO = 1'b1;
`else
    localparam logic AUTO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        dc = 1'b0;
    logic        rdy = 1'b0;
    logic [7:0]  din = 8'h00;
    logic        frame_rdy_out;
    logic        wr_en_out;
    logic [1:0]  wr_addr_out;
    logic [2:0]  byte_en_out;
    logic [7:0]  byte_data_out;
    logic [11:0] layer_en_out;
    logic        overflow_out;

    always #5 clk = ~clk;

    multi_layer_ctl #(
        .LAYERS        (12),
        .LEDS          (4),
        .BYTES_PER_LED (3)
    ) dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .dc_in         (dc),
        .byte_rdy_in   (rdy),
        .byte_data_in  (din),
        .frame_rdy_out (frame_rdy_out),
        .wr_en_out     (wr_en_out),
        .wr_addr_out   (wr_addr_out),
        .byte_en_out   (byte_en_out),
        .byte_data_out (byte_data_out),
        .layer_en_out  (layer_en_out),
        .overflow_out  (overflow_out)
    );

    typedef struct {
        logic        rst, rdy, dc;
        logic [7:0]  d;
        logic        fr, wr;
        logic [1:0]  addr;
        logic [2:0]  be;
        logic [7:0]  bd;
        logic [11:0] le;
        logic        ov;
    } vec_t;

    typedef struct {
        int          idx;
        logic [27:0] val;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    int   cyc = 0;
    logic mon_en = 1'b0;
    int   wr_cnt = 0;
    int   fr_cnt = 0;
    int   fr_cyc = -1;
    int   last_wr_cyc = -1;

    task automatic add(input logic r, input logic v, input logic c, input logic [7:0] d,
                       input logic fr, input logic wr, input logic [1:0] a, input logic [2:0] be,
                       input logic [7:0] bd, input logic [11:0] le, input logic ov);
        vec_t t;
        t.rst = r; t.rdy = v; t.dc = c; t.d = d;
        t.fr = fr; t.wr = wr; t.addr = a; t.be = be; t.bd = bd; t.le = le; t.ov = ov;
        tbl.push_back(t);
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic drive(input logic c, input logic [7:0] d);
        rdy = 1'b1; dc = c; din = d;
        @(posedge clk);
        #1;
        rdy = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc++;

    // Scoreboard: expectations are popped once the DUT has produced its response.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({frame_rdy_out, wr_en_out, wr_addr_out, byte_en_out, byte_data_out,
                 layer_en_out, overflow_out} !== e.val) begin
                errors++;
                $display("FAIL vec%0d: got fr=%b wr=%b addr=%0d be=%b bd=%h le=%h ov=%b, expected fr=%b wr=%b addr=%0d be=%b bd=%h le=%h ov=%b",
                         e.idx, frame_rdy_out, wr_en_out, wr_addr_out, byte_en_out, byte_data_out,
                         layer_en_out, overflow_out, e.val[27], e.val[26], e.val[25:24],
                         e.val[23:21], e.val[20:13], e.val[12:1], e.val[0]);
            end
        end
        if (mon_en) begin
            if (wr_en_out) begin
                wr_cnt++;
                last_wr_cyc = cyc;
            end
            if (frame_rdy_out) begin
                fr_cnt++;
                fr_cyc = cyc;
            end
        end
    end

    initial begin
        // rst rdy dc data | fr wr addr be bd le ov
        add(1, 0, 0, 8'h00, 0, 0, 0, 3'b000, 8'h00, 12'h000, 0);
        add(1, 0, 0, 8'h00, 0, 0, 0, 3'b000, 8'h00, 12'h000, 0);
        add(0, 1, 0, 8'hCC, 0, 0, 0, 3'b000, 8'h00, 12'h000, 0);
        add(0, 1, 1, 8'hA5, 0, 0, 0, 3'b000, 8'h00, 12'h000, 0);
        add(0, 1, 1, 8'h0F, 0, 0, 0, 3'b000, 8'h00, 12'hFA5, 0);
        add(0, 0, 1, 8'h99, 0, 0, 0, 3'b000, 8'h00, 12'hFA5, 0);
        add(0, 1, 0, 8'hDA, 0, 0, 0, 3'b000, 8'h00, 12'hFA5, 0);
        for (int i = 0; i < 12; i++)
            add(0, 1, 1, 8'(i), 0, 1, 2'(i / 3), 3'(1 << (i % 3)), 8'(i), 12'hFA5, 0);
        add(0, 1, 1, 8'h0C, AUTO, 0, 3, 3'b100, 8'h0B, 12'hFA5, 1);
        add(0, 0, 1, 8'h0D, 0,    0, 3, 3'b100, 8'h0B, 12'hFA5, 1);
        add(0, 1, 0, 8'hCC, 0,    0, 3, 3'b100, 8'h0B, 12'hFA5, 1);
        add(0, 1, 1, 8'h00, 0,    0, 3, 3'b100, 8'h0B, 12'hFA5, 1);
        add(0, 1, 0, 8'h3C, 1,    0, 3, 3'b100, 8'h0B, 12'hFA5, 1);
        add(0, 0, 0, 8'h00, 0,    0, 3, 3'b100, 8'h0B, 12'hFA5, 1);
        add(0, 1, 0, 8'hDA, 0,    0, 3, 3'b100, 8'h0B, 12'hFA5, 0);
        add(0, 1, 0, 8'h55, 0,    0, 3, 3'b100, 8'h0B, 12'hFA5, 0);
        add(0, 1, 1, 8'h77, 0,    0, 3, 3'b100, 8'h0B, 12'hFA5, 0);
        add(0, 1, 0, 8'hDA, 0,    0, 3, 3'b100, 8'h0B, 12'hFA5, 0);
        add(0, 1, 1, 8'h11, 0,    1, 0, 3'b001, 8'h11, 12'hFA5, 0);
        add(0, 1, 1, 8'h22, 0,    1, 0, 3'b010, 8'h22, 12'hFA5, 0);
        add(1, 1, 1, 8'h33, 0,    0, 0, 3'b000, 8'h00, 12'h000, 0);
        add(1, 0, 1, 8'h33, 0,    0, 0, 3'b000, 8'h00, 12'h000, 0);
        add(0, 1, 1, 8'h44, 0,    0, 0, 3'b000, 8'h00, 12'h000, 0);
        add(0, 1, 0, 8'hCC, 0,    0, 0, 3'b000, 8'h00, 12'h000, 0);
        add(0, 1, 1, 8'hFF, 0,    0, 0, 3'b000, 8'h00, 12'h000, 0);
        add(0, 1, 1, 8'hFF, 0,    0, 0, 3'b000, 8'h00, 12'hFFF, 0);
        add(0, 1, 1, 8'h5A, 0,    0, 0, 3'b000, 8'h00, 12'hFFF, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            exp_t x;
            rst = tbl[i].rst; rdy = tbl[i].rdy; dc = tbl[i].dc; din = tbl[i].d;
            @(posedge clk);
            x.idx = i;
            x.val = {tbl[i].fr, tbl[i].wr, tbl[i].addr, tbl[i].be, tbl[i].bd, tbl[i].le, tbl[i].ov};
            exp_q.push_back(x);
            #1;
        end
        rst = 1'b0; rdy = 1'b0;
        idle();

        // Full frame with irregular byte gaps, then one byte too many.
        mon_en = 1'b1;
        drive(1'b0, 8'hDA);
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 8'(8'h40 + i));
            repeat ($urandom_range(0, 2)) idle();
        end
        repeat (4) idle();
        chk("gap_writes", wr_cnt, 12);
        chk("auto_pulses", fr_cnt, int'(AUTO));
        if (AUTO)
            chk("auto_delay", fr_cyc - last_wr_cyc, 1);
        drive(1'b1, 8'h99);
        idle();
        chk("gap_overflow", int'(overflow_out), 1);
        chk("gap_no_extra_write", wr_cnt, 12);
        chk("gap_addr_held", int'(wr_addr_out), 3);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_layer_ctl.md
Name: multi_layer_ctl

Overview:
Parametrised successor of the fixed 8-layer command/data decoder. It decodes the DC-qualified SPI byte stream into three things: a layer-enable mask, per-byte pixel-memory write strobes, and a frame-ready pulse. It drives LAYERS layer_out-style channels with BYTES_PER_LED colour bytes per LED (GRB or GRBW). It sits between spi_slave and the layer output instances in the top level.

Parameters:
LAYERS, 8, number of output layers/channels (1..64)
LEDS, 64, LEDs per layer; pixel memory depth (2..1024)
BYTES_PER_LED, 3, colour bytes per LED (3 = GRB, 4 = GRBW)
CMD_LAYER_SEL, 8'hCC, command: load layer-enable mask
CMD_WR_START, 8'hDA, command: start pixel write at address 0
CMD_FRAME_SYNC, 8'h3C, command: emit frame-ready pulse

Ports:
clk_in  in  1  system clock
rst_in  in  1  reset; one clock, synchronous, active-high
dc_in  in  1  0 = command byte, 1 = data byte; sampled with byte_rdy_in
byte_rdy_in  in  1  single-cycle byte-valid strobe
byte_data_in  in  8  received byte
frame_rdy_out  out  1  one-cycle frame-ready pulse
wr_en_out  out  1  one-cycle pixel write strobe
wr_addr_out  out  $clog2(LEDS)  LED index of current write
byte_en_out  out  BYTES_PER_LED  one-hot colour-byte select
byte_data_out  out  8  registered copy of data byte
layer_en_out  out  LAYERS  active layer mask
overflow_out  out  1  sticky: data bytes arrived past the last LED

Behaviour:
- Reset (rst_in=1 at a clk_in edge): every output is 0, the state is IDLE, the mask shadow and counters are cleared. Reset mid-write or mid-mask discards all progress.
- All outputs are registered. Each response appears exactly 1 cycle after the accepting byte_rdy_in edge. Cycles with byte_rdy_in=0 change nothing except returning strobes to 0.
- States:
  - IDLE
  - MASK: collecting mask bytes
  - WRITE: streaming pixel bytes
- Command byte (dc_in=0) is accepted in any state and aborts the current state:
  - CMD_LAYER_SEL -> MASK; mask byte counter = 0.
  - CMD_WR_START -> WRITE; addr = 0, byte index = 0, overflow_out cleared.
  - CMD_FRAME_SYNC -> IDLE; frame_rdy_out = 1 for one cycle.
  - Any other value -> IDLE, no output effect.
- MASK, data byte:
  - Bytes arrive LSB-byte first into a shadow register. MASK_BYTES = ceil(LAYERS/8).
  - On the final byte, layer_en_out <= shadow[LAYERS-1:0] atomically; bits beyond LAYERS are dropped; state -> IDLE.
  - An aborted partial mask leaves layer_en_out unchanged.
- WRITE, data byte:
  - Outputs: wr_en_out = 1, wr_addr_out = addr, byte_en_out = 1 << byte index, byte_data_out = byte.
  - Byte index then increments; at BYTES_PER_LED-1 it wraps to 0 and addr increments.
  - After the last byte of LED LEDS-1, the state moves to a "full" sub-condition (stays WRITE, flag set).
- WRITE full, further data byte: wr_en_out stays 0, overflow_out <= 1 (sticky until the next CMD_WR_START or reset). The address never wraps.
- IDLE, data byte: ignored.
- layer_en_out is not gated internally. Each channel ANDs wr_en_out with its own layer bit.

Optional Feature:
Macro MULTI_LAYER_CTL_AUTO_SYNC_EN.
- Defined: when the final byte of LED LEDS-1 is written, frame_rdy_out pulses 1 cycle after that write strobe (2 cycles after byte_rdy_in). A CMD_FRAME_SYNC still works independently. If both fall in the same cycle, a single pulse is issued.
- Undefined: frame_rdy_out is driven only by CMD_FRAME_SYNC.

Decomposition:
- Package multi_layer_ctl_pkg holds:
  - state enum (IDLE, MASK, WRITE)
  - default command byte constants
  - MASK_BYTES function/localparam
  - ADDR_W = $clog2(LEDS) helper
- One natural sub-module, pixel_write_cnt: the addr/byte-index counter with full flag and one-hot byte_en generation.

Test Plan:
- Reset with LAYERS=8: apply rst_in for 2 cycles mid-write -> all outputs 0 next cycle; a following data byte produces no wr_en_out.
- LAYERS=12: send cmd 0xCC, then data 0xA5, 0x0F -> layer_en_out = 12'hFA5 1 cycle after the second byte; layer_en_out is unchanged after the first byte alone.
- LEDS=4, BYTES_PER_LED=3: send 0xDA, then 12 data bytes 0x00..0x0B:
  - byte 0x05 -> wr_addr_out=1, byte_en_out=3'b100.
  - byte 0x0B -> wr_addr_out=3, byte_en_out=3'b100.
  - a 13th byte -> no wr_en_out, overflow_out=1.
- Send 0xCC, then 1 data byte, then 0x3C -> mask unchanged, frame_rdy_out high for exactly 1 cycle.
- Unknown command 0x55 while in WRITE, then a data byte -> no write; a subsequent 0xDA clears overflow_out.
- With MULTI_LAYER_CTL_AUTO_SYNC_EN, LEDS=2, BYTES_PER_LED=4: send 0xDA plus 8 bytes -> frame_rdy_out pulses once, 2 cycles after the 8th byte_rdy_in. Without the macro -> no pulse.
